// File: rtl/axil_ocl_host_initiator.sv
// AXI-Lite master for the manycore OCL slave port.
// Takes one command at a time from a valid/ready interface, runs the matching
// AXI-Lite write or read, and returns the response on a valid/yumi interface.
// A sticky flag records any transaction that stayed on the bus too long.
module axil_ocl_host_initiator #(
    parameter int axil_addr_width_p = 32,
    parameter int axil_data_width_p = 32,
    parameter int timeout_p         = 1024
) (
    input  logic                           clk_i,
    input  logic                           resetn_i,

    input  logic                           cmd_v_i,
    output logic                           cmd_ready_o,
    input  logic                           cmd_write_i,
    input  logic [axil_addr_width_p-1:0]   cmd_addr_i,
    input  logic [axil_data_width_p-1:0]   cmd_data_i,
    input  logic [axil_data_width_p/8-1:0] cmd_wstrb_i,

    output logic                           rsp_v_o,
    input  logic                           rsp_yumi_i,
    output logic                           rsp_write_o,
    output logic [axil_data_width_p-1:0]   rsp_data_o,
    output logic [1:0]                     rsp_resp_o,
    output logic                           timeout_o,

    output logic [axil_addr_width_p-1:0]   m_axil_awaddr_o,
    output logic                           m_axil_awvalid_o,
    input  logic                           m_axil_awready_i,

    output logic [axil_data_width_p-1:0]   m_axil_wdata_o,
    output logic [axil_data_width_p/8-1:0] m_axil_wstrb_o,
    output logic                           m_axil_wvalid_o,
    input  logic                           m_axil_wready_i,

    input  logic [1:0]                     m_axil_bresp_i,
    input  logic                           m_axil_bvalid_i,
    output logic                           m_axil_bready_o,

    output logic [axil_addr_width_p-1:0]   m_axil_araddr_o,
    output logic                           m_axil_arvalid_o,
    input  logic                           m_axil_arready_i,

    input  logic [axil_data_width_p-1:0]   m_axil_rdata_i,
    input  logic [1:0]                     m_axil_rresp_i,
    input  logic                           m_axil_rvalid_i,
    output logic                           m_axil_rready_o
);

    localparam int strb_width_lp = axil_data_width_p / 8;
    localparam int cnt_width_lp  = $clog2(timeout_p);
    localparam logic [cnt_width_lp-1:0] cnt_max_lp = cnt_width_lp'(timeout_p - 1);
    localparam logic [cnt_width_lp-1:0] cnt_one_lp = cnt_width_lp'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_e;

    state_e                         state_q,     state_d;
    logic [axil_addr_width_p-1:0]   addr_q,      addr_d;
    logic [axil_data_width_p-1:0]   data_q,      data_d;
    logic [strb_width_lp-1:0]       strb_q,      strb_d;
    logic                           aw_done_q,   aw_done_d;
    logic                           w_done_q,    w_done_d;
    logic                           rsp_write_q, rsp_write_d;
    logic [axil_data_width_p-1:0]   rsp_data_q,  rsp_data_d;
    logic [1:0]                     rsp_resp_q,  rsp_resp_d;
    logic                           timeout_q,   timeout_d;
    logic [cnt_width_lp-1:0]        cnt_q,       cnt_d;
    logic                           counting_s;

    // All outputs are decoded from registered state only; no cmd-to-AXI path.
    assign cmd_ready_o      = (state_q == IDLE);
    assign m_axil_awvalid_o = (state_q == WR_REQ) && !aw_done_q;
    assign m_axil_wvalid_o  = (state_q == WR_REQ) && !w_done_q;
    assign m_axil_bready_o  = (state_q == WR_RESP);
    assign m_axil_arvalid_o = (state_q == RD_REQ);
    assign m_axil_rready_o  = (state_q == RD_RESP);
    assign m_axil_awaddr_o  = addr_q;
    assign m_axil_araddr_o  = addr_q;
    assign m_axil_wdata_o   = data_q;
    assign m_axil_wstrb_o   = strb_q;
    assign rsp_v_o          = (state_q == RSP);
    assign rsp_write_o      = rsp_write_q;
    assign rsp_data_o       = rsp_data_q;
    assign rsp_resp_o       = rsp_resp_q;
    assign timeout_o        = timeout_q;

    assign counting_s = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                        (state_q == RD_REQ) || (state_q == RD_RESP);

    // Next-state, command capture, response capture and timeout counter.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        strb_d      = strb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        rsp_write_d = rsp_write_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;
        timeout_d   = timeout_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_v_i) begin
                    addr_d    = cmd_addr_i;
                    data_d    = cmd_data_i;
                    strb_d    = cmd_wstrb_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    cnt_d     = {cnt_width_lp{1'b0}};
                    state_d   = cmd_write_i ? WR_REQ : RD_REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_REQ: begin
                // AW and W complete independently; each valid drops after its own handshake.
                aw_done_d = aw_done_q | m_axil_awready_i;
                w_done_d  = w_done_q  | m_axil_wready_i;
                if (aw_done_d && w_done_d) begin
                    state_d = WR_RESP;
                end else begin
                    state_d = WR_REQ;
                end
            end
            WR_RESP: begin
                if (m_axil_bvalid_i) begin
                    rsp_resp_d  = m_axil_bresp_i;
                    rsp_data_d  = {axil_data_width_p{1'b0}};
                    rsp_write_d = 1'b1;
                    state_d     = RSP;
                end else begin
                    state_d = WR_RESP;
                end
            end
            RD_REQ: begin
                if (m_axil_arready_i) begin
                    state_d = RD_RESP;
                end else begin
                    state_d = RD_REQ;
                end
            end
            RD_RESP: begin
                if (m_axil_rvalid_i) begin
                    rsp_resp_d  = m_axil_rresp_i;
                    rsp_data_d  = m_axil_rdata_i;
                    rsp_write_d = 1'b0;
                    state_d     = RSP;
                end else begin
                    state_d = RD_RESP;
                end
            end
            RSP: begin
                if (rsp_yumi_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RSP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Saturating counter; the flag sets the moment it reaches its limit.
        if (counting_s) begin
            if (cnt_q != cnt_max_lp) begin
                cnt_d = cnt_q + cnt_one_lp;
            end else begin
                cnt_d = cnt_q;
            end
            if (cnt_d == cnt_max_lp) begin
                timeout_d = 1'b1;
            end else begin
                timeout_d = timeout_q;
            end
        end else begin
            timeout_d = timeout_q;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q     <= IDLE;
            addr_q      <= {axil_addr_width_p{1'b0}};
            data_q      <= {axil_data_width_p{1'b0}};
            strb_q      <= {strb_width_lp{1'b0}};
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_data_q  <= {axil_data_width_p{1'b0}};
            rsp_resp_q  <= 2'b00;
            timeout_q   <= 1'b0;
            cnt_q       <= {cnt_width_lp{1'b0}};
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rsp_write_q <= rsp_write_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: doc/axil_ocl_host_initiator.md
Name: axil_ocl_host_initiator

Overview:
- AXI-Lite master that drives the OCL slave port of the manycore wrapper from a simple valid/ready command interface.
- Used in simulation harnesses and on-FPGA self-test, standing in for the host/shell side of the OCL link.
- Issues one read or write at a time, returns the response through a valid/yumi interface, and flags responses that take too long.

Parameters:
- axil_addr_width_p, 32, AXI-Lite address width.
- axil_data_width_p, 32, AXI-Lite data width. Only 32 is supported.
- timeout_p, 1024, cycles from address issue to response before the timeout flag sets. Must be at least 2.

Ports:
- clk_i  in  1  clock
- resetn_i  in  1  synchronous, active-low reset
- cmd_v_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when cmd_v_i & cmd_ready_o
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  axil_addr_width_p  byte address
- cmd_data_i  in  axil_data_width_p  write data
- cmd_wstrb_i  in  axil_data_width_p/8  write strobes
- rsp_v_o  out  1  response valid
- rsp_yumi_i  in  1  response consumed; legal only while rsp_v_o=1
- rsp_write_o  out  1  response belongs to a write
- rsp_data_o  out  axil_data_width_p  read data; 0 for writes
- rsp_resp_o  out  2  BRESP or RRESP
- timeout_o  out  1  sticky: some transaction exceeded timeout_p
- m_axil_awaddr_o, awvalid_o, awready_i  AXI-Lite AW channel
- m_axil_wdata_o, wstrb_o, wvalid_o, wready_i  AXI-Lite W channel
- m_axil_bresp_i, bvalid_i, bready_o  AXI-Lite B channel
- m_axil_araddr_o, arvalid_o, arready_i  AXI-Lite AR channel
- m_axil_rdata_i, rresp_i, rvalid_i, rready_o  AXI-Lite R channel

Behaviour:
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- Reset (resetn_i=0 at posedge clk_i):
  - state returns to IDLE.
  - All valid and ready outputs go to 0, except cmd_ready_o=1.
  - rsp_data_o, rsp_resp_o, rsp_write_o and timeout_o clear to 0; the timeout counter clears to 0.
  - A reset mid-transaction abandons it. The bench must not rely on the slave draining it.
- cmd_ready_o = (state==IDLE). A command accepted in cycle N registers addr, data and strb, and moves to WR_REQ or RD_REQ. The AXI valids assert in cycle N+1; there is no combinational path from cmd to AXI.
- WR_REQ:
  - awvalid_o and wvalid_o assert together.
  - Each channel deasserts independently after its own handshake, tracked by aw_done and w_done flags.
  - AW and W may complete in the same cycle or in either order.
  - Move to WR_RESP once both are done; bready_o=1 in WR_RESP.
- WR_RESP: when bvalid_i=1, capture bresp, set rsp_data_o=0 and rsp_write_o=1, then move to RSP.
- RD_REQ: arvalid_o=1 until arready_i, then move to RD_RESP.
- RD_RESP: rready_o=1. When rvalid_i=1, capture rdata and rresp, set rsp_write_o=0, then move to RSP.
- RSP: rsp_v_o=1, holding stable until rsp_yumi_i, then return to IDLE.
  - A new command cannot be accepted in the same cycle as yumi; the minimum issue interval is one cycle in IDLE.
- Valid stability: every AXI valid, once asserted, stays high with stable payload until its handshake completes.
- Address and payload mapping:
  - awaddr and araddr take the registered address unmodified; no alignment is enforced.
  - wstrb passes through.
- Timeout:
  - The counter clears on command accept and increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When the counter reaches timeout_p-1, timeout_o sets. It is sticky until reset.
  - The transaction is not aborted; the FSM keeps waiting.
  - The counter saturates; it does not wrap.
- Only one transaction is outstanding at a time, so AXI IDs and ordering are not a concern.
- Non-OKAY responses are passed through in rsp_resp_o with no other action.

Test Plan:
- Write 0x0000_0010 / 0xDEAD_BEEF, strb 0xF, awready and wready both high immediately:
  - AW and W handshake in the cycle after accept.
  - bvalid two cycles later → rsp_v_o=1, rsp_write_o=1, rsp_resp_o=0, rsp_data_o=0.
- Write with wready delayed 5 cycles after awready:
  - awvalid drops after its handshake.
  - wvalid holds 0xDEAD_BEEF throughout.
  - bready asserts only after the W handshake.
- Read 0x0000_0004, arready after 3 cycles, R returns 0x1234_5678 with rresp=2 → rsp_data_o=0x1234_5678, rsp_resp_o=2, rsp_write_o=0, timeout_o=0.
- Back-to-back commands with cmd_v_i held high and rsp_yumi_i delayed 4 cycles:
  - cmd_ready_o stays 0 until the cycle after yumi.
  - The second command then issues correctly.
- timeout_p=8, slave never asserts arready → timeout_o rises exactly 8 cycles after accept and stays high; a later arready plus R completes normally.
- Reset asserted while in WR_RESP → next cycle all AXI valids and bready are 0, cmd_ready_o=1, timeout_o=0.
